// File: rtl/seq_serializer_if.sv
// seq_serializer_if: word-in / serial-out bundle between a word source, the serializer and the detector.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             word_last;
    logic             busy;
    modport master (output in_data, in_valid, input in_ready, dout, dout_valid, word_last, busy);
    modport slave  (input in_data, in_valid, output in_ready, dout, dout_valid, word_last, busy);
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: valid/ready word to serial bit stream feeding the sequence detector din.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic              clk,
    input logic              rst_n,
    seq_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH - 1);
`endif
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_dout, r_valid, r_last, r_busy;
    logic             w_ready, w_xfer, w_first, w_next, w_bit;
    logic [WIDTH-1:0] w_load, w_adv;
    assign w_ready = (r_state == IDLE) || r_last;
    assign w_xfer  = bus.in_valid && w_ready;
    assign w_first = (MSB_FIRST != 0) ? bus.in_data[WIDTH-1] : bus.in_data[0];
    assign w_load  = (MSB_FIRST != 0) ? bus.in_data << 1 : bus.in_data >> 1;
    assign w_next  = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
    assign w_adv   = (MSB_FIRST != 0) ? r_shift << 1 : r_shift >> 1;
`ifdef SER_PARITY_EN
    logic r_par;
    // Counter value 1 means all data bits are out; the next bit is parity.
    assign w_bit = (r_cnt == CW'(1)) ? r_par : w_next;
`else
    assign w_bit = w_next;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state <= SHIFT;
            r_shift <= w_load;
            r_cnt   <= LOAD_CNT;
            r_dout  <= w_first;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SER_PARITY_EN
            r_par   <= ^bus.in_data;
`endif
        end else if (r_state == IDLE || r_last) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_shift <= w_adv;
            r_cnt   <= r_cnt - 1'b1;
            r_dout  <= w_bit;
            r_last  <= (r_cnt == CW'(1));
        end
    end
    assign bus.in_ready   = w_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_valid;
    assign bus.word_last  = r_last;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed vectors for 4-bit MSB/LSB-first and 8-bit MSB-first serializers.
module tb_seq_serializer;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W4N = 4 + PAR;
    localparam int W8N = 8 + PAR;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        v_valid [3];
    logic [31:0] v_data  [3];
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    seq_serializer_if #(.WIDTH(4)) if_m ();
    seq_serializer_if #(.WIDTH(4)) if_l ();
    seq_serializer_if #(.WIDTH(8)) if_8 ();
    assign if_m.in_valid = v_valid[0];
    assign if_m.in_data  = v_data[0][3:0];
    assign if_l.in_valid = v_valid[1];
    assign if_l.in_data  = v_data[1][3:0];
    assign if_8.in_valid = v_valid[2];
    assign if_8.in_data  = v_data[2][7:0];
    seq_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
    seq_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
    seq_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_8 (.clk(clk), .rst_n(rst_n), .bus(if_8));
    typedef struct {
        logic [3:0] data;
        logic [3:0] exp_m;
        logic [3:0] exp_l;
        logic       par;
    } vec_t;
    vec_t tbl [6];
    // {in_ready, busy, word_last, dout_valid, dout}
    function automatic logic [4:0] obs(input int d);
        case (d)
            0:       return {if_m.in_ready, if_m.busy, if_m.word_last, if_m.dout_valid, if_m.dout};
            1:       return {if_l.in_ready, if_l.busy, if_l.word_last, if_l.dout_valid, if_l.dout};
            default: return {if_8.in_ready, if_8.busy, if_8.word_last, if_8.dout_valid, if_8.dout};
        endcase
    endfunction
    function automatic logic [63:0] app(input logic [63:0] s, input logic [31:0] bits, input int w, input logic p);
        logic [63:0] r;
        r = (s << w) | 64'(bits);
        if (PAR != 0) r = (r << 1) | 64'(p);
        return r;
    endfunction
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask
    // Called at the negedge after the accepting edge; checks n serial cycles then idle.
    task automatic expect_stream(input int d, input string tag, input logic [63:0] bits, input int n,
                                 input int wlen, input int drop_i, input int change_i, input logic [31:0] data2);
        logic [4:0] o;
        for (int i = 0; i < n; i++) begin
            o = obs(d);
            chk({tag, "_dout"}, i, 32'(o[0]), 32'(bits[n-1-i]));
            chk({tag, "_valid"}, i, 32'(o[1]), 32'd1);
            chk({tag, "_last"}, i, 32'(o[2]), 32'((i % wlen) == wlen - 1));
            chk({tag, "_busy"}, i, 32'(o[3]), 32'd1);
            chk({tag, "_ready"}, i, 32'(o[4]), 32'((i % wlen) == wlen - 1));
            if (i == change_i) v_data[d] = data2;
            if (i == drop_i) v_valid[d] = 1'b0;
            @(negedge clk);
        end
        o = obs(d);
        chk({tag, "_idle"}, 0, 32'(o), 32'b10000);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        logic [4:0] o;
        tbl[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
        tbl[1] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
        tbl[2] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};
        tbl[3] = '{4'b0111, 4'b0111, 4'b1110, 1'b1};
        tbl[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
        tbl[5] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
        for (int d = 0; d < 3; d++) begin
            v_valid[d] = 1'b0;
            v_data[d]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = obs(d);
            chk("reset_outs", d, 32'(o[3:0]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = obs(d);
            chk("post_reset", d, 32'(o), 32'b10000);
        end
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) begin
                v_data[d]  = 32'(tbl[k].data);
                v_valid[d] = 1'b1;
                @(negedge clk);
                expect_stream(d, d == 0 ? "msb" : "lsb",
                              app(64'd0, 32'(d == 0 ? tbl[k].exp_m : tbl[k].exp_l), 4, tbl[k].par),
                              W4N, W4N, 0, -1, 32'd0);
            end
        end
        // Back-to-back with in_valid held: new word taken in the word_last cycle.
        v_data[0]  = 32'h0000000B;
        v_valid[0] = 1'b1;
        @(negedge clk);
        expect_stream(0, "b2b", app(app(64'd0, 32'b1011, 4, 1'b1), 32'b0110, 4, 1'b0),
                      2 * W4N, W4N, W4N, 0, 32'h00000006);
        // in_data changes to FF mid-word; 3C stays intact, FF follows as the next word.
        v_data[2]  = 32'h0000003C;
        v_valid[2] = 1'b1;
        @(negedge clk);
        expect_stream(2, "hold", app(app(64'd0, 32'b00111100, 8, 1'b0), 32'b11111111, 8, 1'b0),
                      2 * W8N, W8N, W8N, 1, 32'h000000FF);
        // Reset mid-word after the second bit of A5.
        v_data[2]  = 32'h000000A5;
        v_valid[2] = 1'b1;
        @(negedge clk);
        v_valid[2] = 1'b0;
        o = obs(2);
        chk("rst_bit1", 0, 32'(o[1:0]), 32'b11);
        @(negedge clk);
        o = obs(2);
        chk("rst_bit2", 0, 32'(o[1:0]), 32'b10);
        rst_n = 1'b0;
        #1;
        o = obs(2);
        chk("rst_async", 0, 32'(o[3:0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        o = obs(2);
        chk("rst_ready", 0, 32'(o[4]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            o = obs(2);
            chk("rst_no_resume", i, 32'(o[3:0]), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial feeder that sits directly upstream of the sequence detector and drives its serial `din` input one bit per clock.
- Accepts words over a valid/ready handshake and shifts each word out, MSB-first or LSB-first.
- Provides qualifying strobes so downstream logic and benches can align detector flags to word boundaries.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; connects to the detector `din`.
- dout_valid  output  1  dout carries a live data bit (or parity bit, see Optional Feature).
- word_last  output  1  high during the final bit of each word.
- busy  output  1  high while a word is being shifted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; shift register=0; bit counter=0; dout=0, dout_valid=0, word_last=0, busy=0. in_ready=1 once rst_n=1.
- Transfer occurs on a rising edge where in_valid && in_ready. in_valid may be held; no transfer happens without in_ready.
- FSM states:
  - IDLE: in_ready=1, dout_valid=0, dout=0. On transfer: load in_data, drive its first bit on dout at that same edge (registered), set dout_valid=1 and busy=1, counter=WIDTH-1, go to SHIFT.
  - SHIFT: on each edge, shift the next bit onto dout and decrement the counter. word_last=1 when the bit on dout is the final bit of the word (counter==0).
  - in_ready = (state==IDLE) || word_last.
  - Last bit with no transfer: next edge returns to IDLE; dout=0, dout_valid=0, busy=0.
- Latency: first bit appears on dout in the cycle after the accepting edge. A WIDTH-bit word occupies exactly WIDTH consecutive dout_valid cycles.
- Back-to-back: a transfer during word_last loads the new word and drives its first bit on the next edge, with zero idle gap. The detector therefore sees a continuous stream across word boundaries, and patterns spanning two words must be detectable.
- in_data is sampled only at the transfer edge. Later changes to in_data do not affect the word in flight.
- in_valid deasserted mid-word: no effect on the word in flight.
- rst_n asserted mid-word: the word is discarded, all outputs go to their reset values immediately, and no partial bits resume after release.
- Counter width: $clog2(WIDTH+1) bits. No wrap beyond WIDTH-1.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: after the last data bit, one extra bit carrying even parity (XOR of all WIDTH data bits) is shifted, with dout_valid=1. word_last moves to the parity cycle, so each word occupies WIDTH+1 cycles and back-to-back acceptance occurs in the parity cycle.
- Not defined: no parity cycle; behaviour exactly as above.

Test Plan:
- WIDTH=4, MSB_FIRST=1, in_data=4'b1011 accepted at edge k -> dout=1,0,1,1 on cycles k+1..k+4; dout_valid high for those 4 cycles; word_last only at k+4; attached detector raises flag per its spec.
- Back-to-back 4'b1011 then 4'b0110 with in_valid held -> dout=1,0,1,1,0,1,1,0 with no gap; in_ready high only in IDLE and the word_last cycles.
- MSB_FIRST=0, in_data=4'b1011 -> dout=1,1,0,1.
- rst_n low for 1 cycle after the 2nd bit of 8'hA5 -> dout=0, dout_valid=0, busy=0 immediately; after release in_ready=1 and no remaining bits of 8'hA5 appear.
- in_valid=1 with in_data changing to 8'hFF at cycle k+2 after 8'h3C is accepted at k -> serial output is still 0,0,1,1,1,1,0,0.
- SER_PARITY_EN defined, WIDTH=4, in_data=4'b1011 -> dout=1,0,1,1,1; word_last on the 5th bit.
